// File: rtl/tea_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tea_stream_ctrl
//
// Stream-side controller for a TEA cipher/decipher core. It collects a
// two-word block (V0 then V1) from a valid/ready input stream, presents the
// block and a registered key to the core, fires a one-cycle start pulse for
// the selected direction, waits a bounded number of cycles for the matching
// done flag, and then streams the two result words (C0 then C1) out over a
// valid/ready output stream.
//
// Ports
//   clk              clock, all state on the rising edge
//   rst              asynchronous, active-low reset
//   iData/iValid     input stream word (V0 first, then V1) and its valid
//   oReady           controller accepts iData this cycle (IDLE and LOAD1)
//   iMode            0 = cipher, 1 = decipher; taken with the V0 word
//   iKeyLoad         load iK0..iK3 into the key registers (IDLE only)
//   iK0..iK3         key words
//   oV0, oV1         block words presented to the core
//   oK0..oK3         registered key presented to the core
//   oStartCipher     one-cycle start pulse, cipher direction
//   oStartDecipher   one-cycle start pulse, decipher direction
//   iC0, iC1         core result words
//   iDoneCipher      core completion flag, cipher direction
//   iDoneDecipher    core completion flag, decipher direction
//   oData/oValid     output stream word (C0 first, then C1) and its valid
//   iReady           downstream accepts oData
//   oBusy            high in every state except IDLE
//   oError           one-cycle pulse when the core fails to finish in time
// -----------------------------------------------------------------------------
module tea_stream_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] iData,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic                 iMode,
  input  logic                 iKeyLoad,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic [WORD_SIZE-1:0] oV0,
  output logic [WORD_SIZE-1:0] oV1,
  output logic [WORD_SIZE-1:0] oK0,
  output logic [WORD_SIZE-1:0] oK1,
  output logic [WORD_SIZE-1:0] oK2,
  output logic [WORD_SIZE-1:0] oK3,
  output logic                 oStartCipher,
  output logic                 oStartDecipher,
  input  logic [WORD_SIZE-1:0] iC0,
  input  logic [WORD_SIZE-1:0] iC1,
  input  logic                 iDoneCipher,
  input  logic                 iDoneDecipher,
  output logic [WORD_SIZE-1:0] oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oBusy,
  output logic                 oError
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT0  = 3'd4,
    S_OUT1  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WORD_SIZE-1:0] r_v0, r_v1;
  logic [WORD_SIZE-1:0] r_k0, r_k1, r_k2, r_k3;
  logic [WORD_SIZE-1:0] r_c0, r_c1;
  logic                 r_mode;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_start_c;
  logic                 r_start_d;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_busy;
  logic                 w_valid;
  logic [WORD_SIZE-1:0] w_data;
  logic                 w_xfer;
  logic                 w_done;
  logic                 w_limit;

  // Only the done flag of the direction that was started is observed.
  assign w_done  = r_mode ? iDoneDecipher : iDoneCipher;
  assign w_xfer  = iValid & w_ready;
  // The current WAIT cycle is the last one allowed: the count of WAIT cycles
  // already spent without done is one short of the limit.
  assign w_limit = (r_cnt >= CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_LOAD1;
      S_LOAD1: if (w_xfer) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        // Done wins over the timeout limit when both happen together.
        if (w_done) begin
          w_next = S_OUT0;
        end else if (w_limit) begin
          w_next = S_IDLE;
        end
      end
      S_OUT0:  if (iReady) w_next = S_OUT1;
      S_OUT1:  if (iReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (all derived from registered state and data)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b1;
    w_valid = 1'b0;
    w_data  = r_c0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      S_LOAD1: w_ready = 1'b1;
      S_OUT0: begin
        w_valid = 1'b1;
        w_data  = r_c0;
      end
      S_OUT1: begin
        w_valid = 1'b1;
        w_data  = r_c1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Block, mode and key registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0   <= '0;
      r_v1   <= '0;
      r_mode <= 1'b0;
      r_k0   <= '0;
      r_k1   <= '0;
      r_k2   <= '0;
      r_k3   <= '0;
    end else begin
      if (r_state == S_IDLE && w_xfer) begin
        r_v0   <= iData;
        r_mode <= iMode;
      end
      if (r_state == S_LOAD1 && w_xfer) begin
        r_v1 <= iData;
      end
      // Keys change only in IDLE, so they are frozen for the whole block.
      if (r_state == S_IDLE && iKeyLoad) begin
        r_k0 <= iK0;
        r_k1 <= iK1;
        r_k2 <= iK2;
        r_k3 <= iK3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c0  <= '0;
      r_c1  <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_WAIT && w_done) begin
        r_c0 <= iC0;
        r_c1 <= iC1;
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !w_done && r_cnt < CNT_W'(TIMEOUT)) begin
        // Saturating: the counter never wraps back to zero.
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered control pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_c <= 1'b0;
      r_start_d <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Pulses are high exactly while the FSM sits in START.
      r_start_c <= (w_next == S_START) && !r_mode;
      r_start_d <= (w_next == S_START) &&  r_mode;
      r_err     <= (r_state == S_WAIT) && !w_done && w_limit;
    end
  end

  assign oReady         = w_ready;
  assign oBusy          = w_busy;
  assign oValid         = w_valid;
  assign oData          = w_data;
  assign oV0            = r_v0;
  assign oV1            = r_v1;
  assign oK0            = r_k0;
  assign oK1            = r_k1;
  assign oK2            = r_k2;
  assign oK3            = r_k3;
  assign oStartCipher   = r_start_c;
  assign oStartDecipher = r_start_d;
  assign oError         = r_err;

endmodule

// File: tb/tb_tea_stream_ctrl.sv
module tb_tea_stream_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] iData;
  logic        iValid;
  logic        oReady;
  logic        iMode;
  logic        iKeyLoad;
  logic [31:0] iK0, iK1, iK2, iK3;
  logic [31:0] oV0, oV1, oK0, oK1, oK2, oK3;
  logic        oStartCipher, oStartDecipher;
  logic [31:0] iC0, iC1;
  logic        iDoneCipher, iDoneDecipher;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oBusy;
  logic        oError;

  tea_stream_ctrl #(.WORD_SIZE(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .iData(iData), .iValid(iValid), .oReady(oReady),
    .iMode(iMode), .iKeyLoad(iKeyLoad),
    .iK0(iK0), .iK1(iK1), .iK2(iK2), .iK3(iK3),
    .oV0(oV0), .oV1(oV1),
    .oK0(oK0), .oK1(oK1), .oK2(oK2), .oK3(oK3),
    .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher),
    .iC0(iC0), .iC1(iC1),
    .iDoneCipher(iDoneCipher), .iDoneDecipher(iDoneDecipher),
    .oData(oData), .oValid(oValid), .iReady(iReady),
    .oBusy(oBusy), .oError(oError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;

  // Output-stream handshake counter, used to detect lost/duplicated words.
  always @(posedge clk) begin
    if (oValid && iReady) xfer_cnt <= xfer_cnt + 1;
  end

  logic [31:0] e_v0, e_v1;
  logic [31:0] e_k [4];

  typedef struct {
    logic        mode;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        kl;
    logic [31:0] k0, k1, k2, k3;
    int          done_at;   // edge after START at which done is sampled; 0 = never
    logic [31:0] c0;
    logic [31:0] c1;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Transfers V0 (with mode and optional key load) and V1; returns in START.
  task automatic send_block(input logic mode, input logic [31:0] v0, input logic [31:0] v1,
                            input logic kl, input logic [31:0] k0, input logic [31:0] k1,
                            input logic [31:0] k2, input logic [31:0] k3);
    check("ready_idle", {31'd0, oReady}, 32'd1);
    iValid = 1'b1; iData = v0; iMode = mode;
    iKeyLoad = kl; iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
    if (kl) begin
      e_k[0] = k0; e_k[1] = k1; e_k[2] = k2; e_k[3] = k3;
    end
    e_v0 = v0; e_v1 = v1;
    @(posedge clk); #1;
    iKeyLoad = 1'b0;
    iMode = ~mode;
    check("load1_ready_busy", {30'd0, oReady, oBusy}, 32'd3);
    iData = v1;
    @(posedge clk); #1;
    iValid = 1'b0;
    iData = 32'hFFFF_FFFF;
    check("start_ready", {31'd0, oReady}, 32'd0);
    check("start_pulses", {30'd0, oStartCipher, oStartDecipher}, {30'd0, ~mode, mode});
    check("start_v0", oV0, e_v0);
    check("start_v1", oV1, e_v1);
    check("start_k0", oK0, e_k[0]);
    check("start_k1", oK1, e_k[1]);
    check("start_k2", oK2, e_k[2]);
    check("start_k3", oK3, e_k[3]);
  endtask

  // Stub core; the wrong-direction done flag is held high to prove it is ignored.
  task automatic wait_core(input logic mode, input int done_at,
                           input logic [31:0] c0, input logic [31:0] c1);
    logic vbad, ebad, sbad, kbad;
    vbad = 0; ebad = 0; sbad = 0; kbad = 0;
    iC0 = c0; iC1 = c1;
    for (int k = 1; k < ((done_at == 0) ? 65 : done_at); k++) begin
      if (mode) iDoneCipher = 1'b1; else iDoneDecipher = 1'b1;
      @(posedge clk); #1;
      if (oValid) vbad = 1;
      if (oError) ebad = 1;
      if (oStartCipher || oStartDecipher) sbad = 1;
      if (oV0 !== e_v0 || oV1 !== e_v1 || oK0 !== e_k[0] || oK1 !== e_k[1] ||
          oK2 !== e_k[2] || oK3 !== e_k[3]) kbad = 1;
    end
    check("wait_no_valid", {31'd0, vbad}, 32'd0);
    check("wait_no_error", {31'd0, ebad}, 32'd0);
    check("wait_single_start", {31'd0, sbad}, 32'd0);
    check("wait_regs_stable", {31'd0, kbad}, 32'd0);
    if (done_at == 0) begin
      check("timeout_busy_64", {31'd0, oBusy}, 32'd1);
      @(posedge clk); #1;
      iDoneCipher = 1'b0; iDoneDecipher = 1'b0;
      check("timeout_err_pulse", {31'd0, oError}, 32'd1);
      check("timeout_idle", {29'd0, oBusy, oReady, oValid}, 32'b010);
      @(posedge clk); #1;
      check("timeout_err_one_cycle", {30'd0, oError, oValid}, 32'd0);
    end else begin
      iDoneCipher = 1'b0; iDoneDecipher = 1'b0;
      if (mode) iDoneDecipher = 1'b1; else iDoneCipher = 1'b1;
      @(posedge clk); #1;
      iDoneCipher = 1'b0; iDoneDecipher = 1'b0;
      iC0 = ~c0; iC1 = ~c1;
      check("out0_valid", {30'd0, oValid, oError}, 32'b10);
      check("out0_data", oData, c0);
    end
  endtask

  // From OUT0 with iReady=1: C1 next, then back to IDLE; exactly two words move.
  task automatic drain(input logic [31:0] c1);
    int x0;
    x0 = xfer_cnt;
    iReady = 1'b1;
    @(posedge clk); #1;
    check("out1_valid", {31'd0, oValid}, 32'd1);
    check("out1_data", oData, c1);
    @(posedge clk); #1;
    check("done_idle", {29'd0, oValid, oBusy, oReady}, 32'b001);
    check("xfer_count", xfer_cnt - x0, 32'd2);
  endtask

  initial begin
    logic bad;
    int   x0;
    rst = 1'b0; iData = '0; iValid = 0; iMode = 0; iKeyLoad = 0;
    iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0; iC0 = '0; iC1 = '0;
    iDoneCipher = 0; iDoneDecipher = 0; iReady = 1'b1;
    e_k[0] = '0; e_k[1] = '0; e_k[2] = '0; e_k[3] = '0;
    e_v0 = '0; e_v1 = '0;

    tbl[0] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 6, 32'h41EA3A0A, 32'h94BAA940, 1'b0};
    tbl[1] = '{1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 6, 32'hDEADBEEF, 32'h01234567, 1'b0};
    tbl[2] = '{1'b0, 32'h11111111, 32'h22222222, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 2, 32'hCAFEF00D, 32'h8BADF00D, 1'b0};
    tbl[3] = '{1'b1, 32'h33333333, 32'h44444444, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 65, 32'h13572468, 32'h24681357, 1'b0};
    tbl[4] = '{1'b0, 32'h55555555, 32'h66666666, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 32'h77777777, 32'h88888888, 1'b1, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 0, 32'h0, 32'h0, 1'b1};
    tbl[6] = '{1'b0, 32'h99999999, 32'hAAAAAAAA, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3, 32'h0BADCAFE, 32'hFEEDFACE, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {26'd0, oReady, oBusy, oValid, oError, oStartCipher, oStartDecipher}, 32'b100000);
    check("rst_k0", oK0, 32'h0);
    check("rst_v0", oV0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_flags", {26'd0, oReady, oBusy, oValid, oError, oStartCipher, oStartDecipher}, 32'b100000);

    // Table-driven blocks
    for (int i = 0; i < 7; i++) begin
      send_block(tbl[i].mode, tbl[i].v0, tbl[i].v1, tbl[i].kl,
                 tbl[i].k0, tbl[i].k1, tbl[i].k2, tbl[i].k3);
      wait_core(tbl[i].mode, tbl[i].done_at, tbl[i].c0, tbl[i].c1);
      if (!tbl[i].exp_err) drain(tbl[i].c1);
    end

    // Backpressure in OUT0 and OUT1
    x0 = xfer_cnt;
    send_block(1'b0, 32'h12121212, 32'h34343434, 1'b0, '0, '0, '0, '0);
    iReady = 1'b0;
    wait_core(1'b0, 4, 32'hC0C0C0C0, 32'hC1C1C1C1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!oValid || oData !== 32'hC0C0C0C0) bad = 1;
    end
    check("bp_out0_stable", {31'd0, bad}, 32'd0);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    check("bp_out1_data", oData, 32'hC1C1C1C1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (!oValid || oData !== 32'hC1C1C1C1) bad = 1;
    end
    check("bp_out1_stable", {31'd0, bad}, 32'd0);
    iReady = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {30'd0, oValid, oBusy}, 32'd0);
    check("bp_xfer_count", xfer_cnt - x0, 32'd2);

    // Reset in the middle of WAIT, then a late done flag in IDLE
    send_block(1'b0, 32'hABABABAB, 32'hCDCDCDCD, 1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_flags", {26'd0, oReady, oBusy, oValid, oError, oStartCipher, oStartDecipher}, 32'b100000);
    @(posedge clk); #1;
    rst = 1'b1;
    e_k[0] = '0; e_k[1] = '0; e_k[2] = '0; e_k[3] = '0;
    iDoneCipher = 1'b1; iC0 = 32'h66666666;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (oValid || oBusy || oError) bad = 1;
    end
    iDoneCipher = 1'b0;
    check("abort_late_done_ignored", {31'd0, bad}, 32'd0);
    send_block(1'b0, 32'h0F1E2D3C, 32'h4B5A6978, 1'b0, '0, '0, '0, '0);
    wait_core(1'b0, 5, 32'h11223344, 32'h55667788);
    drain(32'h55667788);

    // Key load attempted during WAIT is ignored
    send_block(1'b1, 32'h01010101, 32'h02020202, 1'b1, 32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000, 32'hDDDD0000);
    iKeyLoad = 1'b1;
    iK0 = 32'h9999_9999; iK1 = 32'h8888_8888; iK2 = 32'h7777_7777; iK3 = 32'h6666_6666;
    wait_core(1'b1, 5, 32'hEEEE1111, 32'hEEEE2222);
    iKeyLoad = 1'b0;
    check("keyload_wait_k0", oK0, 32'hAAAA0000);
    drain(32'hEEEE2222);
    send_block(1'b0, 32'h03030303, 32'h04040404, 1'b1, 32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000);
    wait_core(1'b0, 3, 32'h76543210, 32'hFEDCBA98);
    drain(32'hFEDCBA98);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
